// File: rtl/aes_tbox_pkg.sv
// ============================================================================
// Module      : aes_tbox_pkg
// Description : Shared constants, S-box table and T-table placement helpers
//               for the AES T-table lookup pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_tbox_pkg;

  localparam int NW_DEFAULT    = 4;
  localparam int TAG_W_DEFAULT = 4;

  localparam logic [7:0] RED_POLY = 8'h1b;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_FINAL  = 1'b1
  } tbox_mode_e;

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] lo;
    lo = {~x, 3'b000};
    return SBOX_TABLE[lo +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] tbox_normal(input logic [7:0] s, input logic [1:0] pos);
    logic [7:0] s2;
    logic [7:0] s3;
    logic [31:0] r;
    s2 = xtime(s);
    s3 = s2 ^ s;
    case (pos)
      2'd0:    r = {s2, s,  s,  s3};
      2'd1:    r = {s3, s2, s,  s };
      2'd2:    r = {s,  s3, s2, s };
      default: r = {s,  s,  s3, s2};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] tbox_final(input logic [7:0] s, input logic [1:0] pos);
    logic [31:0] r;
    case (pos)
      2'd0:    r = {s, 24'h0};
      2'd1:    r = {8'h0, s, 16'h0};
      2'd2:    r = {16'h0, s, 8'h0};
      default: r = {24'h0, s};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] tbox_place(input logic [7:0] s, input logic [1:0] pos,
                                             input tbox_mode_e mode);
    return (mode == MODE_FINAL) ? tbox_final(s, pos) : tbox_normal(s, pos);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_tbox_pipe_if.sv
// ============================================================================
// Module      : aes_tbox_pipe_if
// Description : Valid/ready input and output channels of the T-table engine.
//               TBOX_FINAL_EN adds the per-transaction in_final mode bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_tbox_pipe_if #(
  parameter int NW    = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NW*32-1:0]     in_state;
`ifdef TBOX_FINAL_EN
  logic                 in_final;
`endif
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [NW*128-1:0]    out_p;
  logic [TAG_W-1:0]     out_tag;

`ifdef TBOX_FINAL_EN
  modport master (output in_valid, in_state, in_final, in_tag, out_ready,
                  input  in_ready, out_valid, out_p, out_tag);
  modport slave  (input  in_valid, in_state, in_final, in_tag, out_ready,
                  output in_ready, out_valid, out_p, out_tag);
`else
  modport master (output in_valid, in_state, in_tag, out_ready,
                  input  in_ready, out_valid, out_p, out_tag);
  modport slave  (input  in_valid, in_state, in_tag, out_ready,
                  output in_ready, out_valid, out_p, out_tag);
`endif

endinterface

`default_nettype wire

// File: rtl/aes_tbox_lane.sv
// ============================================================================
// Module      : aes_tbox_lane
// Description : One 32-bit state word: four enabled synchronous S-box reads
//               followed by the registered xtime/XOR/placement stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_tbox_lane
  import aes_tbox_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [31:0]  word_i,
  input  tbox_mode_e   mode_i,
  output logic [127:0] p_o
);

  logic [3:0][7:0] s_q;
  logic [3:0][7:0] s_d;
  logic [127:0]    p_q;
  logic [127:0]    p_d;

  // mode_i belongs to the stage-1 transaction, so it pairs with s_q.
  always_comb begin
    s_d = s_q;
    p_d = p_q;
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        s_d[b]                = sbox(word_i[8*(3-b) +: 8]);
        p_d[32*(3-b) +: 32]   = tbox_place(s_q[b], 2'(b), mode_i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

`default_nettype wire

// File: rtl/aes_tbox_pipe.sv
// ============================================================================
// Module      : aes_tbox_pipe
// Description : Two-stage pipelined AES T-table lookup with valid/ready flow
//               control. Optional final-round mode under TBOX_FINAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_tbox_pipe
  import aes_tbox_pkg::*;
#(
  parameter int NW    = NW_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_tbox_pipe_if.slave bus
);

  logic             adv;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  tbox_mode_e       mode_s1;

  // The whole pipe advances together; bubbles are not collapsed.
  always_comb begin
    adv    = !v2_q || bus.out_ready;
    v1_d   = adv ? bus.in_valid : v1_q;
    v2_d   = adv ? v1_q         : v2_q;
    tag1_d = adv ? bus.in_tag   : tag1_q;
    tag2_d = adv ? tag1_q       : tag2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

`ifdef TBOX_FINAL_EN
  tbox_mode_e mode1_q, mode1_d;

  always_comb begin
    mode1_d = mode1_q;
    if (adv) mode1_d = bus.in_final ? MODE_FINAL : MODE_NORMAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode1_q <= MODE_NORMAL;
    else        mode1_q <= mode1_d;
  end

  assign mode_s1 = mode1_q;
`else
  assign mode_s1 = MODE_NORMAL;
`endif

  for (genvar w = 0; w < NW; w++) begin : g_lane
    aes_tbox_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .word_i (bus.in_state[32*w +: 32]),
      .mode_i (mode_s1),
      .p_o    (bus.out_p[128*w +: 128])
    );
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v2_q;
  assign bus.out_tag   = tag2_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_tbox_pipe.sv
// ============================================================================
// Module      : tb_aes_tbox_pipe
// Description : Self-checking bench: directed vectors, back-to-back, random
//               stall traffic against a GF(2^8) reference model, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_tbox_pipe;

  localparam int NW    = 4;
  localparam int TAG_W = 4;
  localparam int PW    = NW * 128;
  localparam int SW    = NW * 32;

  logic clk;
  logic rst_n;
  logic fin_drv;

  aes_tbox_pipe_if #(.NW(NW), .TAG_W(TAG_W)) bus ();

`ifdef TBOX_FINAL_EN
  assign bus.in_final = fin_drv;
`endif

  aes_tbox_pipe #(.NW(NW), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference S-box from field inverse plus affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // p_b byte k = S * M[k][b], M being the MixColumns matrix.
  function automatic logic [PW-1:0] ref_p(input logic [SW-1:0] st, input bit fin);
    logic [7:0]    mc [4][4];
    logic [PW-1:0] r = '0;
    mc = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
           '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++) begin
        logic [7:0] s = sb[st[32*w + 8*(3-b) +: 8]];
        for (int k = 0; k < 4; k++)
          r[128*w + 32*(3-b) + 8*(3-k) +: 8] = fin ? ((k == b) ? s : 8'h00) : gmul(s, mc[k][b]);
      end
    return r;
  endfunction

  typedef struct packed {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_ctr;
  int   first_pop;
  int   last_pop;

  task automatic directed(input string nm, input logic [SW-1:0] st, input bit fin,
                          input logic [PW-1:0] ex);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_state  = st;
    bus.in_tag    = 4'hA;
    fin_drv       = fin;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 512'(bus.in_ready), 512'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    fin_drv      = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 512'(bus.out_valid), 512'(0));
    @(negedge clk);
    chk({nm, "_lat2_valid"}, 512'(bus.out_valid), 512'(1));
    chk({nm, "_p"}, 512'(bus.out_p), 512'(ex));
    chk({nm, "_tag"}, 512'(bus.out_tag), 512'(4'hA));
  endtask

  task automatic run_traffic(input string nm, input int n_tx, input int vpct, input int rpct,
                             input bit rnd_mode);
    int               sent = 0;
    int               got  = 0;
    int               cyc  = 0;
    int               budget = n_tx * 20 + 50;
    bit               acc  = 1'b0;
    bit               hold = 1'b0;
    logic [PW-1:0]    hp   = '0;
    logic [TAG_W-1:0] ht   = '0;
    exp_t             e;
    first_pop = -1;
    last_pop  = -1;
    while ((sent < n_tx || exp_q.size() != 0) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      cyc_ctr++;
      if (!(bus.in_valid && !acc)) begin
        bus.in_valid = (sent < n_tx) && (($urandom % 100) < vpct);
        for (int w = 0; w < NW; w++) bus.in_state[32*w +: 32] = $urandom;
        bus.in_tag = sent[TAG_W-1:0];
        fin_drv    = rnd_mode ? 1'($urandom % 2) : 1'b0;
      end
      bus.out_ready = ($urandom % 100) < rpct;
      @(negedge clk);
      if (hold) begin
        chk({nm, "_stall_valid"}, 512'(bus.out_valid), 512'(1));
        chk({nm, "_stall_p"}, 512'(bus.out_p), 512'(hp));
        chk({nm, "_stall_tag"}, 512'(bus.out_tag), 512'(ht));
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        exp_q.push_back('{p: ref_p(bus.in_state, fin_drv), tag: bus.in_tag});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_spurious_out"}, 512'(bus.out_valid), 512'(0));
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_p"}, 512'(bus.out_p), 512'(e.p));
          chk({nm, "_tag"}, 512'(bus.out_tag), 512'(e.tag));
          if (got == 0) first_pop = cyc;
          last_pop = cyc;
          got++;
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hp   = bus.out_p;
      ht   = bus.out_tag;
    end
    if (cyc >= budget) chk({nm, "_timeout_pending"}, 512'(exp_q.size()), 512'(0));
    chk({nm, "_count"}, 512'(got), 512'(n_tx));
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    fin_drv       = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] st;
    logic [PW-1:0] ex;
    bit            mixed = 1'b0;
`ifdef TBOX_FINAL_EN
    mixed = 1'b1;
`endif
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    fin_drv       = 1'b0;
    cyc_ctr       = 0;
    build_sbox();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_out_p", 512'(bus.out_p), 512'(0));
    chk("rst_out_tag", 512'(bus.out_tag), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));

    st = '0;
    ex = '0;
    for (int w = 0; w < NW; w++)
      ex[128*w +: 128] = {32'hc66363a5, 32'ha5c66363, 32'h63a5c663, 32'h6363a5c6};
    directed("zero", st, 1'b0, ex);

    st[31:0]   = 32'h53000000;
    ex[127:96] = 32'hc1eded2c;
    directed("x53", st, 1'b0, ex);

`ifdef TBOX_FINAL_EN
    st = '0;
    st[31:0] = 32'h00010203;
    for (int w = 0; w < NW; w++)
      ex[128*w +: 128] = {32'h63000000, 32'h00630000, 32'h00006300, 32'h00000063};
    ex[127:0] = {32'h63000000, 32'h007c0000, 32'h00007700, 32'h0000007b};
    directed("final", st, 1'b1, ex);
`endif

    run_traffic("b2b", 8, 100, 100, 1'b0);
    chk("b2b_consecutive", 512'(last_pop - first_pop), 512'(7));

    run_traffic("rand", 1000, 70, 50, mixed);

    // Two transactions in flight, then asynchronous reset.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = {NW{32'h0badf00d}};
    bus.in_tag    = 4'h5;
    @(posedge clk); #1;
    bus.in_tag    = 4'h6;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("midrst_out_p", 512'(bus.out_p), 512'(0));
    chk("midrst_out_tag", 512'(bus.out_tag), 512'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", 512'(bus.out_valid), 512'(0));
    end
    chk("postrst_in_ready", 512'(bus.in_ready), 512'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/aes_tbox_pipe.md
# aes_tbox_pipe

Parametrised, pipelined AES T-table lookup engine with valid/ready flow control. It accepts NW 32-bit state words per transaction and returns the four rotated T-table words (p0..p3) for every byte of every word. It sits between the round-state register and the AddRoundKey XOR tree of the round datapath and replaces the free-running, handshake-free single-word lookup.

## Interface
Parameters:
- NW, 4, number of 32-bit state words per transaction (1..4)
- TAG_W, 4, width of the sideband tag carried alongside the data

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  input transaction valid
- in_ready  out  1  engine accepts the input this cycle
- in_state  in  NW*32  state words; word w is bits [32w+31:32w]; byte b0 is the MSB
- in_final  in  1  final-round mode (S-box only, no MixColumns); present only with TBOX_FINAL_EN
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts the output
- out_p  out  NW*128  per word w: {p0,p1,p2,p3} at bits [128w+127:128w]; p0 is the MSB
- out_tag  out  TAG_W  tag of the output transaction

## Operation
- Per byte x: S = Sbox(x). 2S = xtime(S) = {S[6:0],0} ^ (S[7] ? 8'h1b : 0). 3S = S ^ 2S.
- Normal mode: p0 = {2S(b0),S(b0),S(b0),3S(b0)}, p1 = {3S(b1),2S(b1),S(b1),S(b1)}, p2 = {S(b2),3S(b2),2S(b2),S(b2)}, p3 = {S(b3),S(b3),3S(b3),2S(b3)}.
- Final mode: p0 = {S(b0),0,0,0}, p1 = {0,S(b1),0,0}, p2 = {0,0,S(b2),0}, p3 = {0,0,0,S(b3)}.
- Two-stage pipeline:
  - Stage 1: synchronous S-box read (4*NW lookups), with tag and mode registered.
  - Stage 2: xtime, XOR and byte placement, registered into out_p.
- Global advance: adv = !v2 | out_ready. in_ready = adv. Stage 1 loads in_valid & adv. Stage 2 loads v1 when adv. ROM reads are enabled by adv, so data holds under stall.
- No bubble collapse. A v1 bubble behind a stalled v2 stays in place.
- out_p and out_tag are stable while out_valid & !out_ready.

## Timing
- Latency: 2 cycles from accept (in_valid & in_ready) to out_valid, given no stall.
- Throughput: 1 transaction per cycle while out_ready is high.
- Reset values: v1 = v2 = 0, out_valid = 0, out_p = 0, out_tag = 0. in_ready is 1 once reset is released.
- Reset mid-operation: all in-flight transactions are discarded. No output appears for them after reset.
- Simultaneous accept and drain with a full pipe: both occur in the same cycle, with no loss and no duplicate.
- When out_ready is low with v2 = 1: in_ready = 0 in the same cycle (combinational path from out_ready).

## Configuration
- TBOX_FINAL_EN defined: the in_final port exists. Mode is registered per transaction and applied in stage 2, so mixed-mode back-to-back traffic is legal.
- TBOX_FINAL_EN undefined: the in_final port is absent and every transaction uses normal mode.

## Structure
- Package aes_tbox_pkg holds:
  - the 256-entry S-box constant
  - the xtime function
  - the reduction constant 8'h1b
  - NW and TAG_W defaults
  - the p0..p3 placement function for each mode
- One sub-module, aes_tbox_lane, handles one 32-bit word: four synchronous S-box reads with enable, followed by the stage-2 combine. It is instantiated NW times. The top level holds the valid, tag and handshake logic.

## Test plan
- NW=1, in_state=0x00000000, normal mode -> after 2 cycles: p0=0xc66363a5, p1=0xa5c66363, p2=0x63a5c663, p3=0x6363a5c6.
- NW=1, in_state=0x53000000 -> p0=0xc1eded2c; p1..p3 as in the first scenario.
- TBOX_FINAL_EN, in_final=1, in_state=0x00010203 -> p0=0x63000000, p1=0x007c0000, p2=0x00007700, p3=0x0000007b.
- Back-to-back: 8 transactions, out_ready=1 -> 8 outputs on consecutive cycles, tags 0..7 in order.
- Random out_ready (50%) over 1000 transactions vs. reference model -> no loss or duplication; out_p and out_tag held stable during stall.
- rst_n pulsed low with 2 transactions in flight -> out_valid=0 and out_p=0 immediately; no stale output after release.
